// File: rtl/edu_tpu_wb_host_pkg.sv
// Shared definitions for the edu_tpu Wishbone host:
// default target, TPU protocol word counts and host FSM states.
package edu_tpu_wb_host_pkg;

    localparam logic [31:0] TPU_BASE_ADDRESS = 32'h3000_0000;

    localparam int TPU_WEIGHT_WORDS = 3;
    localparam int TPU_INPUT_WORDS  = 6;
    localparam int TPU_RESULT_WORDS = 10;

    localparam logic [1:0] HOST_IDLE = 2'd0;
    localparam logic [1:0] HOST_BUS  = 2'd1;
    localparam logic [1:0] HOST_GAP  = 2'd2;

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } rsp_t;

endpackage

// File: rtl/edu_tpu_rsp_fifo.sv
// In-order response FIFO for the Wishbone host.
// Entries are {err,dat}; the head reads as zero when empty.
module edu_tpu_rsp_fifo
    import edu_tpu_wb_host_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  rsp_t        push_data,
    input  logic        pop,
    output rsp_t        head,
    output logic [AW:0] count
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    rsp_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/edu_tpu_wb_host.sv
// Single-outstanding Wishbone classic master feeding the edu_tpu slave.
// One bus transfer and one in-order response per accepted command.
module edu_tpu_wb_host
    import edu_tpu_wb_host_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = TPU_BASE_ADDRESS,
    parameter int          TIMEOUT      = 15,
    parameter int          RSP_DEPTH    = 4
) (
    input  logic        caravel_wb_clk_i,
    input  logic        caravel_wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic        cmd_adr_use_base,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int              CW       = $clog2(RSP_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C  = CW'(RSP_DEPTH);
    localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [7:0]    timer;
    logic          cyc_stb;
    logic [CW-1:0] fifo_count;
    logic          accept;
    logic          push;
    logic          pop;
    rsp_t          push_data;
    rsp_t          head;

    assign cmd_ready = !caravel_wb_rst_i && (state == HOST_IDLE)
                       && (fifo_count < DEPTH_C);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != HOST_IDLE);
    assign wbm_cyc_o = cyc_stb;
    assign wbm_stb_o = cyc_stb;

    // Ack wins over the timeout when both land on the same cycle.
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        if (state == HOST_BUS) begin
            if (wbm_ack_i) begin
                push          = 1'b1;
                push_data.dat = wbm_we_o ? 32'h0 : wbm_dat_i;
            end else if (timer == TMO_LAST) begin
                push          = 1'b1;
                push_data.err = 1'b1;
            end
        end
    end

    always_ff @(posedge caravel_wb_clk_i) begin
        if (caravel_wb_rst_i) begin
            state     <= HOST_IDLE;
            timer     <= '0;
            cyc_stb   <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else begin
            case (state)
                HOST_IDLE: begin
                    if (accept) begin
                        state     <= HOST_BUS;
                        timer     <= '0;
                        cyc_stb   <= 1'b1;
                        wbm_we_o  <= cmd_we;
                        wbm_sel_o <= cmd_sel;
                        wbm_adr_o <= cmd_adr_use_base ? BASE_ADDRESS : cmd_adr;
                        wbm_dat_o <= cmd_dat;
                    end
                end
                HOST_BUS: begin
                    if (push) begin
                        cyc_stb <= 1'b0;
                        state   <= HOST_GAP;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                // Idle cycle lets a level-held ack fall before the next strobe.
                HOST_GAP: begin
                    state <= HOST_IDLE;
                end
                default: begin
                    state   <= HOST_IDLE;
                    cyc_stb <= 1'b0;
                end
            endcase
        end
    end

    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = (fifo_count != '0);
    assign rsp_dat   = head.dat;
    assign rsp_err   = head.err;

    edu_tpu_rsp_fifo #(
        .DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (caravel_wb_clk_i),
        .rst      (caravel_wb_rst_i),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_edu_tpu_wb_host.sv
// Directed bench for edu_tpu_wb_host with a behavioural
// Wishbone slave (programmable ack delay, no-ack, held ack).
module tb_edu_tpu_wb_host;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic        cmd_adr_use_base;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    localparam logic [31:0] BASE = 32'h3000_0000;

    edu_tpu_wb_host dut (
        .caravel_wb_clk_i(clk),
        .caravel_wb_rst_i(rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_we          (cmd_we),
        .cmd_adr_use_base(cmd_adr_use_base),
        .cmd_adr         (cmd_adr),
        .cmd_dat         (cmd_dat),
        .cmd_sel         (cmd_sel),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_dat         (rsp_dat),
        .rsp_err         (rsp_err),
        .busy            (busy),
        .wbm_cyc_o       (wbm_cyc_o),
        .wbm_stb_o       (wbm_stb_o),
        .wbm_we_o        (wbm_we_o),
        .wbm_sel_o       (wbm_sel_o),
        .wbm_adr_o       (wbm_adr_o),
        .wbm_dat_o       (wbm_dat_o),
        .wbm_dat_i       (wbm_dat_i),
        .wbm_ack_i       (wbm_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slave
    int          ack_delay;
    bit          hold_ack;
    bit          dat_by_adr;
    logic [31:0] slave_rdata;
    int          stb_cnt;

    always @(posedge clk) stb_cnt <= wbm_stb_o ? stb_cnt + 1 : 0;

    assign wbm_ack_i = hold_ack ||
                       (wbm_stb_o && ack_delay >= 0 && stb_cnt == ack_delay);
    assign wbm_dat_i = dat_by_adr ? (wbm_adr_o ^ 32'h5A5A_0000) : slave_rdata;

    // Strobe pulse monitor
    int cur_w;
    int last_w;
    int pulses;
    int low_run;
    int last_gap;
    int cyc_err;
    int n_pop;

    initial begin
        stb_cnt  = 0;
        cur_w    = 0;
        last_w   = 0;
        pulses   = 0;
        low_run  = 0;
        last_gap = 0;
        cyc_err  = 0;
        n_pop    = 0;
    end

    always @(negedge clk) begin
        if (wbm_stb_o) begin
            if (cur_w == 0) begin
                last_gap = low_run;
            end
            cur_w++;
            low_run = 0;
        end else begin
            low_run++;
            if (cur_w != 0) begin
                last_w = cur_w;
                pulses++;
                cur_w = 0;
            end
        end
        if (wbm_cyc_o !== wbm_stb_o) cyc_err++;
        if (rsp_valid && rsp_ready) n_pop++;
    end

    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit we, input bit ub,
                         input logic [31:0] adr, input logic [31:0] dat);
        cmd_valid        = 1'b1;
        cmd_we           = we;
        cmd_adr_use_base = ub;
        cmd_adr          = adr;
        cmd_dat          = dat;
        cmd_sel          = 4'hF;
    endtask

    task automatic wait_accept(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ok) step();
        cmd_valid = 1'b0;
    endtask

    task automatic issue(input string tag, input bit we, input bit ub,
                         input logic [31:0] adr, input logic [31:0] dat);
        bit ok;
        drive(we, ub, adr, dat);
        wait_accept(40, ok);
        chk({tag, " accept"}, ok, 1);
    endtask

    task automatic take_rsp(input string tag, input logic [31:0] exp_dat,
                            input logic exp_err);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk({tag, " rsp_valid"}, found, 1);
        chk({tag, " rsp_dat"}, rsp_dat, exp_dat);
        chk({tag, " rsp_err"}, rsp_err, exp_err);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    int p0;
    int q0;
    bit ok5;

    initial begin
        n_chk            = 0;
        n_pass           = 0;
        rst              = 1'b1;
        cmd_valid        = 1'b0;
        cmd_we           = 1'b0;
        cmd_adr_use_base = 1'b0;
        cmd_adr          = '0;
        cmd_dat          = '0;
        cmd_sel          = '0;
        rsp_ready        = 1'b0;
        ack_delay        = 1;
        hold_ack         = 1'b0;
        dat_by_adr       = 1'b0;
        slave_rdata      = 32'h1234_5678;

        repeat (3) step();
        chk("rst cyc/stb/we", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 0);
        chk("rst sel/adr", {wbm_sel_o, wbm_adr_o}, 0);
        chk("rst dat_o", wbm_dat_o, 0);
        chk("rst cmd_ready", cmd_ready, 0);
        chk("rst rsp", {rsp_valid, rsp_err, rsp_dat}, 0);
        chk("rst busy", busy, 0);
        rst = 1'b0;
        step();
        chk("idle cmd_ready", cmd_ready, 1);

        // 1: write to base, ack one cycle after strobe
        p0 = pulses;
        issue("t1", 1, 1, 32'hDEAD_0000, 32'h0000_0102);
        chk("t1 stb", wbm_stb_o, 1);
        chk("t1 adr", wbm_adr_o, BASE);
        chk("t1 dat_o", wbm_dat_o, 32'h0000_0102);
        chk("t1 we/sel", {wbm_we_o, wbm_sel_o}, 5'h1F);
        chk("t1 busy", busy, 1);
        take_rsp("t1", 32'h0, 1'b0);
        chk("t1 width", last_w, 2);
        chk("t1 pulses", pulses - p0, 1);

        // 2: read base, immediate ack
        ack_delay   = 0;
        slave_rdata = 32'hDEAD_BEEF;
        issue("t2", 0, 1, 32'h0, 32'h0);
        chk("t2 adr/we", {wbm_we_o, wbm_adr_o}, {1'b0, BASE});
        take_rsp("t2", 32'hDEAD_BEEF, 1'b0);
        chk("t2 width", last_w, 1);

        // 3: explicit address, slave never acks
        ack_delay = -1;
        issue("t3", 0, 0, 32'h3000_0010, 32'h0);
        chk("t3 adr", wbm_adr_o, 32'h3000_0010);
        take_rsp("t3", 32'h0, 1'b1);
        chk("t3 width", last_w, 15);

        // 4: fill the response FIFO, then one pop admits the fifth
        ack_delay  = 0;
        dat_by_adr = 1'b1;
        p0         = pulses;
        for (int k = 0; k < 4; k++) begin
            issue("t4", 0, 0, 32'h100 + 32'(4 * k), 32'h0);
        end
        drive(0, 0, 32'h110, 32'h0);
        repeat (8) step();
        chk("t4 full ready", cmd_ready, 0);
        chk("t4 pulses4", pulses - p0, 4);
        take_rsp("t4 r0", 32'h5A5A_0100, 1'b0);
        wait_accept(20, ok5);
        chk("t4 fifth accept", ok5, 1);
        take_rsp("t4 r1", 32'h5A5A_0104, 1'b0);
        take_rsp("t4 r2", 32'h5A5A_0108, 1'b0);
        take_rsp("t4 r3", 32'h5A5A_010C, 1'b0);
        take_rsp("t4 r4", 32'h5A5A_0110, 1'b0);
        chk("t4 pulses5", pulses - p0, 5);
        dat_by_adr = 1'b0;

        // 5: ack held high everywhere
        ack_delay = -1;
        hold_ack  = 1'b1;
        repeat (4) step();
        chk("t5 idle ack ignored", rsp_valid, 0);
        rsp_ready = 1'b1;
        p0        = pulses;
        q0        = n_pop;
        for (int k = 0; k < 3; k++) begin
            issue("t5", 1, 1, 32'h0, 32'(k));
        end
        repeat (5) step();
        chk("t5 pulses", pulses - p0, 3);
        chk("t5 width", last_w, 1);
        chk("t5 gap", last_gap, 2);
        chk("t5 pops", n_pop - q0, 3);
        chk("t5 drained", rsp_valid, 0);
        rsp_ready = 1'b0;
        hold_ack  = 1'b0;

        // 6: reset with a pending response and a strobe in flight
        issue("t6a", 1, 1, 32'h0, 32'h55);
        repeat (20) step();
        chk("t6 pending", rsp_valid, 1);
        issue("t6b", 1, 1, 32'h0, 32'h66);
        step();
        chk("t6 stb before rst", wbm_stb_o, 1);
        rst = 1'b1;
        step();
        chk("t6 rst cyc/stb", {wbm_cyc_o, wbm_stb_o}, 0);
        chk("t6 rst rsp_valid", rsp_valid, 0);
        chk("t6 rst busy", busy, 0);
        rst = 1'b0;
        step();
        ack_delay = 1;
        p0        = pulses;
        issue("t6c", 1, 1, 32'h0, 32'h0000_CAFE);
        chk("t6c dat_o", wbm_dat_o, 32'h0000_CAFE);
        take_rsp("t6c", 32'h0, 1'b0);
        chk("t6c width", last_w, 2);
        step();
        chk("t6c nothing stale", rsp_valid, 0);

        chk("cyc equals stb", cyc_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
